dcache_wb_unit: RTL and testbench

- D-cache writeback (eviction) engine; reads one full dirty line out of the byte-banked D-cache data array.
- Captures the line into a local buffer, then streams it to memory as a burst: address phase, data beats, write response.
- Sits between the dcache miss/evict controller (request side) and the L2/memory write port (bus side).
- Exactly one writeback is in flight at a time.

---
 rtl/dcache_pkg.sv | 17 +
 rtl/dcache_wb_beat_ser.sv | 38 +++
 rtl/dcache_wb_unit.sv | 143 ++++++++++++++
 tb/tb_dcache_wb_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants and FSM encoding for the D-cache writeback engine.
package dcache_pkg;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int NBEATS = LINE_W / BEAT_W;
  localparam logic [LINE_W/8-1:0] BYTE_CHOSE_ALL = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARR_RD  = 3'd1,
    S_ARR_CAP = 3'd2,
    S_AW      = 3'd3,
    S_W       = 3'd4,
    S_B       = 3'd5,
    S_DONE    = 3'd6
  } wb_state_t;
endpackage

// File: rtl/dcache_wb_beat_ser.sv
// Line buffer plus beat serializer; beats go out in ascending order, data held while stalled.
module dcache_wb_beat_ser
  import dcache_pkg::*;
#(
  parameter int LINE = LINE_W,
  parameter int BEAT = BEAT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_cap_en,
  input  logic [LINE-1:0] i_line,
  input  logic            i_cnt_clr,
  input  logic            i_beat_hs,
  output logic [BEAT-1:0] o_beat_dat,
  output logic            o_beat_last,
  output logic            o_last_done
);
  localparam int NB    = LINE / BEAT;
  localparam int CNT_W = $clog2(NB);

  logic [LINE-1:0]  r_buf;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_cap_en) r_buf <= i_line;
  end

  // Counter parks on the last beat; it is only cleared by a new address phase.
  always_ff @(posedge clk) begin
    if (rst)                         r_cnt <= '0;
    else if (i_cnt_clr)              r_cnt <= '0;
    else if (i_beat_hs && !o_beat_last) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_beat_last = (r_cnt == CNT_W'(NB - 1));
  assign o_beat_dat  = r_buf[int'(r_cnt) * BEAT +: BEAT];
  assign o_last_done = i_beat_hs && o_beat_last;
endmodule

// File: rtl/dcache_wb_unit.sv
// D-cache writeback engine: array read, line capture, AW/W burst, B response. 9 cycles accept->done at full rate.
// Optional DCACHE_WB_RETRY_EN: one resend of the captured line after a first error response.
module dcache_wb_unit
  import dcache_pkg::*;
#(
  parameter int LINE  = LINE_W,
  parameter int ADDR  = 8,
  parameter int BEAT  = LINE_W / NBEATS,
  parameter int PADDR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_req_valid,
  output logic              wb_req_ready,
  input  logic [ADDR-1:0]   wb_req_set,
  input  logic [PADDR-1:0]  wb_req_paddr,
  output logic              arr_chip_en,
  output logic              arr_write_en,
  output logic [ADDR-1:0]   arr_addr,
  output logic [LINE/8-1:0] arr_byte_chose,
  input  logic [LINE-1:0]   arr_read_data,
  output logic              mem_aw_valid,
  input  logic              mem_aw_ready,
  output logic [PADDR-1:0]  mem_aw_addr,
  output logic [7:0]        mem_aw_len,
  output logic              mem_w_valid,
  input  logic              mem_w_ready,
  output logic [BEAT-1:0]   mem_w_data,
  output logic              mem_w_last,
  input  logic              mem_b_valid,
  input  logic              mem_b_err,
  output logic              wb_done,
  output logic              wb_err,
  output logic              busy
);
  localparam logic [PADDR-1:0] OFF_MASK = PADDR'(LINE / 8 - 1);

  wb_state_t        r_state, w_state_nxt;
  logic [ADDR-1:0]  r_set;
  logic [PADDR-1:0] r_paddr;
  logic             r_aw_vld, r_w_vld, r_done, r_err;
  logic             w_accept, w_aw_hs, w_w_hs, w_last_done, w_err_nxt;
`ifdef DCACHE_WB_RETRY_EN
  logic             r_retry, w_retry_set;
`endif

  assign w_accept = (r_state == S_IDLE) && wb_req_valid;
  assign w_aw_hs  = r_aw_vld && mem_aw_ready;
  assign w_w_hs   = r_w_vld && mem_w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
`ifdef DCACHE_WB_RETRY_EN
    w_retry_set = 1'b0;
`endif
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_ARR_RD;
      S_ARR_RD:  w_state_nxt = S_ARR_CAP;
      S_ARR_CAP: w_state_nxt = S_AW;
      S_AW:      if (w_aw_hs) w_state_nxt = S_W;
      S_W:       if (w_last_done) w_state_nxt = S_B;
      S_B: begin
        if (mem_b_valid) begin
`ifdef DCACHE_WB_RETRY_EN
          if (mem_b_err && !r_retry) begin
            w_state_nxt = S_AW;
            w_retry_set = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_err_nxt   = mem_b_err;
          end
`else
          w_state_nxt = S_DONE;
          w_err_nxt   = mem_b_err;
`endif
        end
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Bus valids and completion flags come straight from flops keyed on the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_aw_vld <= 1'b0;
      r_w_vld  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_aw_vld <= (w_state_nxt == S_AW);
      r_w_vld  <= (w_state_nxt == S_W);
      r_done   <= (w_state_nxt == S_DONE);
      r_err    <= w_err_nxt;
    end
  end

`ifdef DCACHE_WB_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst)              r_retry <= 1'b0;
    else if (w_accept)    r_retry <= 1'b0;
    else if (w_retry_set) r_retry <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_set   <= wb_req_set;
      r_paddr <= wb_req_paddr;
    end
  end

  dcache_wb_beat_ser #(
    .LINE (LINE),
    .BEAT (BEAT)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_cap_en    (r_state == S_ARR_CAP),
    .i_line      (arr_read_data),
    .i_cnt_clr   (w_aw_hs),
    .i_beat_hs   (w_w_hs),
    .o_beat_dat  (mem_w_data),
    .o_beat_last (mem_w_last),
    .o_last_done (w_last_done)
  );

  assign wb_req_ready   = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign arr_chip_en    = (r_state == S_ARR_RD);
  assign arr_write_en   = 1'b0;
  assign arr_addr       = r_set;
  assign arr_byte_chose = arr_chip_en ? (LINE/8)'(BYTE_CHOSE_ALL) : '0;
  assign mem_aw_valid   = r_aw_vld;
  assign mem_aw_addr    = r_paddr & ~OFF_MASK;
  assign mem_aw_len     = 8'(LINE / BEAT - 1);
  assign mem_w_valid    = r_w_vld;
  assign wb_done        = r_done;
  assign wb_err         = r_err;
endmodule

// File: tb/tb_dcache_wb_unit.sv
// Bench for dcache_wb_unit: array model, bus responder and scoreboard of expected AW/W/done events.
module tb_dcache_wb_unit;
  logic         clk = 1'b0;
  logic         rst;
  logic         wb_req_valid, wb_req_ready;
  logic [7:0]   wb_req_set;
  logic [31:0]  wb_req_paddr;
  logic         arr_chip_en, arr_write_en;
  logic [7:0]   arr_addr;
  logic [31:0]  arr_byte_chose;
  logic [255:0] arr_read_data;
  logic         mem_aw_valid, mem_aw_ready;
  logic [31:0]  mem_aw_addr;
  logic [7:0]   mem_aw_len;
  logic         mem_w_valid, mem_w_ready;
  logic [63:0]  mem_w_data;
  logic         mem_w_last;
  logic         mem_b_valid, mem_b_err;
  logic         wb_done, wb_err, busy;

  dcache_wb_unit dut (
    .clk(clk), .rst(rst),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_set(wb_req_set), .wb_req_paddr(wb_req_paddr),
    .arr_chip_en(arr_chip_en), .arr_write_en(arr_write_en), .arr_addr(arr_addr),
    .arr_byte_chose(arr_byte_chose), .arr_read_data(arr_read_data),
    .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready),
    .mem_aw_addr(mem_aw_addr), .mem_aw_len(mem_aw_len),
    .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
    .mem_w_data(mem_w_data), .mem_w_last(mem_w_last),
    .mem_b_valid(mem_b_valid), .mem_b_err(mem_b_err),
    .wb_done(wb_done), .wb_err(wb_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [255:0] arr_mem [0:255];
  always @(posedge clk) if (arr_chip_en) arr_read_data <= arr_mem[arr_addr];

  logic [31:0] q_aw   [$];
  logic [64:0] q_beat [$];
  logic        q_done [$];
  logic        q_b    [$];

  int   aw_stall = 0;
  int   hs_cnt = 0;
  int   t_acc = 0;
  int   t_done = 0;
  bit   w_tog = 0, spur = 0, b_pending = 0, mdl_busy = 0, lat_chk = 0;
  bit   aw_stalled = 0, w_stalled = 0;
  logic [7:0] cur_set = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Responder drives bus inputs at negedge, then scores what will handshake at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (b_pending) begin
        mem_b_valid = 1'b1;
        mem_b_err   = (q_b.size() > 0) ? q_b.pop_front() : 1'b0;
        b_pending   = 0;
      end else begin
        mem_b_valid = spur;
        mem_b_err   = spur;
      end
      if (aw_stall > 0 && mem_aw_valid) begin
        mem_aw_ready = 1'b0;
        aw_stall--;
      end else mem_aw_ready = 1'b1;
      mem_w_ready = w_tog ? ~mem_w_ready : 1'b1;

      if (rst) begin
        q_aw.delete(); q_beat.delete(); q_done.delete(); q_b.delete();
        b_pending = 0; hs_cnt = 0; mdl_busy = 0; lat_chk = 0;
        aw_stalled = 0; w_stalled = 0;
      end else begin
        chk("busy", busy, mdl_busy);
        chk("req_ready", wb_req_ready, !mdl_busy);
        if (arr_chip_en) begin
          chk("arr_addr", arr_addr, cur_set);
          chk("arr_byte_chose", arr_byte_chose, 32'hFFFF_FFFF);
          chk("arr_write_en", arr_write_en, 0);
          if (lat_chk) chk("rd_lat", cyc + 1 - t_acc, 1);
        end
        if (aw_stalled) chk("aw_hold", mem_aw_valid, 1);
        if (mem_aw_valid && mem_aw_ready) begin
          chk("aw_expected", q_aw.size() != 0, 1);
          if (q_aw.size() != 0) begin
            chk("aw_addr", mem_aw_addr, q_aw.pop_front());
            chk("aw_len", mem_aw_len, 3);
          end
        end
        aw_stalled = mem_aw_valid && !mem_aw_ready;
        if (w_stalled) chk("w_hold", mem_w_valid, 1);
        if (mem_w_valid && !mem_w_ready && q_beat.size() != 0) begin
          chk("w_stall_dat", mem_w_data, q_beat[0][63:0]);
          chk("w_stall_last", mem_w_last, q_beat[0][64]);
        end
        if (mem_w_valid && mem_w_ready) begin
          chk("w_expected", q_beat.size() != 0, 1);
          if (q_beat.size() != 0) begin
            logic [64:0] e;
            e = q_beat.pop_front();
            chk("w_dat", mem_w_data, e[63:0]);
            chk("w_last", mem_w_last, e[64]);
            hs_cnt++;
            if (e[64]) begin
              chk("burst_beats", hs_cnt, 4);
              hs_cnt = 0;
              b_pending = 1;
            end
          end
        end
        w_stalled = mem_w_valid && !mem_w_ready;
        if (wb_done) begin
          chk("done_in_flight", mdl_busy, 1);
          if (q_done.size() != 0) chk("wb_err", wb_err, q_done.pop_front());
          if (lat_chk) chk("done_lat", cyc + 1 - t_acc, 9);
          t_done   = cyc + 1;
          mdl_busy = 0;
        end
        if (wb_req_valid && wb_req_ready) begin
          t_acc    = cyc + 1;
          mdl_busy = 1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] set, input logic [31:0] pa, input int nburst,
                      input logic exp_err, input bit lat);
    logic [255:0] line;
    int n = 0;
    line = arr_mem[set];
    for (int b = 0; b < nburst; b++) begin
      q_aw.push_back(pa & 32'hFFFF_FFE0);
      for (int i = 0; i < 4; i++) q_beat.push_back({(i == 3), line[i*64 +: 64]});
    end
    q_done.push_back(exp_err);
    @(posedge clk); #1;
    lat_chk = lat;
    cur_set = set;
    wb_req_set = set;
    wb_req_paddr = pa;
    wb_req_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!wb_req_ready && n < 200);
    chk("req_accept_tmo", n < 200, 1);
    @(posedge clk); #1;
    wb_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mdl_busy || q_done.size() != 0) && n < 500) begin @(negedge clk); n++; end
    chk("idle_tmo", n < 500, 1);
    chk("beats_left", q_beat.size(), 0);
    chk("aw_left", q_aw.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; wb_req_valid = 0; wb_req_set = '0; wb_req_paddr = '0;
    mem_aw_ready = 1; mem_w_ready = 1; mem_b_valid = 0; mem_b_err = 0;
    for (int s = 0; s < 256; s++)
      for (int b = 0; b < 32; b++) arr_mem[s][b*8 +: 8] = 8'($urandom);
    for (int b = 0; b < 32; b++) arr_mem[8'h3A][b*8 +: 8] = 8'(b);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_aw_valid", mem_aw_valid, 0);
    chk("rst_w_valid", mem_w_valid, 0);
    chk("rst_done", wb_done, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_chip_en", arr_chip_en, 0);
    chk("rst_byte_chose", arr_byte_chose, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", wb_req_ready, 1);

    // Full-rate writeback with the known byte-ramp line.
    q_b.push_back(0);
    send(8'h3A, 32'h8000_1040, 1, 0, 1);
    wait_idle();

    // AW stalled three cycles, W ready toggling; unaligned paddr must be masked.
    aw_stall = 3; w_tog = 1;
    q_b.push_back(0);
    send(8'h11, 32'h1234_567B, 1, 0, 0);
    wait_idle();
    w_tog = 0;

    // Second request raised while the first is streaming beats.
    q_b.push_back(0); q_b.push_back(0);
    send(8'h22, 32'h0000_2000, 1, 0, 0);
    n = 0;
    while (!mem_w_valid && n < 50) begin @(negedge clk); n++; end
    chk("w_start_tmo", n < 50, 1);
    send(8'h23, 32'h0000_2020, 1, 0, 0);
    chk("acc_after_done", t_acc - t_done, 1);
    wait_idle();

`ifdef DCACHE_WB_RETRY_EN
    q_b.push_back(1); q_b.push_back(0);
    send(8'h40, 32'h4000_0100, 2, 0, 0);
    wait_idle();
    q_b.push_back(1); q_b.push_back(1);
    send(8'h41, 32'h4000_0120, 2, 1, 0);
    wait_idle();
`else
    q_b.push_back(1);
    send(8'h40, 32'h4000_0100, 1, 1, 1);
    wait_idle();
`endif

    // Reset while the engine holds beat index 2.
    q_b.push_back(0);
    send(8'h55, 32'h5555_0040, 1, 0, 0);
    n = 0;
    do begin @(posedge clk); n++; end while (hs_cnt < 2 && n < 50);
    chk("beat2_tmo", n < 50, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_aw_valid", mem_aw_valid, 0);
    chk("mid_rst_w_valid", mem_w_valid, 0);
    chk("mid_rst_done", wb_done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", wb_req_ready, 1);
    q_b.push_back(0);
    send(8'h56, 32'h5555_0060, 1, 0, 1);
    wait_idle();

    // Error-flagged b_valid outside the response phase must be ignored.
    spur = 1;
    repeat (5) @(negedge clk);
    q_b.push_back(0);
    send(8'h77, 32'h7700_00E0, 1, 0, 1);
    wait_idle();
    spur = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
